// File: rtl/ring_scan_controller.sv
// ---------------------------------------------------------------------------
// ring_scan_controller
//
// Purpose:
//   Sequencer for the one-hot ring counter in the light-scan game. It makes
//   the counter's step-enable pulses at one of four rates and drives the
//   counter's clear. It also runs an IDLE/CLEAR/RUN/RESULT game FSM. When the
//   player stops, it samples the ring position and reports hit or miss against
//   a target slot. It also counts completed laps of the ring.
//
// Ports:
//   clk         in   system clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   start       in   start/restart pulse (one cycle)
//   stop        in   stop pulse (one cycle)
//   speed[1:0]  in   step rate select, period = DIV_BASE >> speed
//   pos         in   one-hot position fed back from the ring counter
//   ring_en     out  one-cycle step enable to the ring counter
//   ring_rst_n  out  active-low synchronous clear to the ring counter
//   busy        out  high while in CLEAR or RUN
//   hit         out  stop landed on TARGET_IDX (valid in RESULT)
//   miss        out  stop landed elsewhere or pos was not one-hot
//   cap_pos     out  pos captured at stop
//   lap_cnt     out  completed wraps since start, saturating at 255
// ---------------------------------------------------------------------------
module ring_scan_controller #(
  parameter int RING_LEN   = 15,
  parameter int DIV_BASE   = 1000000,
  parameter int DIV_WIDTH  = 20,
  parameter int TARGET_IDX = 7
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                stop,
  input  logic [1:0]          speed,
  input  logic [RING_LEN-1:0] pos,
  output logic                ring_en,
  output logic                ring_rst_n,
  output logic                busy,
  output logic                hit,
  output logic                miss,
  output logic [RING_LEN-1:0] cap_pos,
  output logic [7:0]          lap_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_RESULT
  } state_t;

  localparam logic [DIV_WIDTH-1:0] BASE_PERIOD = DIV_WIDTH'(DIV_BASE);
  localparam logic [DIV_WIDTH-1:0] ONE_COUNT   = {{(DIV_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [RING_LEN-1:0]  TARGET_MASK =
    {{(RING_LEN-1){1'b0}}, 1'b1} << TARGET_IDX;

  state_t               r_state;
  logic [DIV_WIDTH-1:0] r_presc;
  logic [DIV_WIDTH-1:0] r_period;
  logic                 r_ring_en;
  logic                 r_ring_rst_n;
  logic                 r_busy;
  logic                 r_hit;
  logic                 r_miss;
  logic [RING_LEN-1:0]  r_cap_pos;
  logic [7:0]           r_lap_cnt;

  logic [DIV_WIDTH-1:0] w_speed_period;
  logic [DIV_WIDTH-1:0] w_last_count;
  logic                 w_wrap;
  logic                 w_pos_hit;
  logic                 w_lap_step;

  // The step period comes from the live speed input. It is only loaded into
  // r_period in CLEAR and at each prescaler wrap, so a speed change never
  // cuts a step short.
  assign w_speed_period = BASE_PERIOD >> speed;
  assign w_last_count   = r_period - ONE_COUNT;
  assign w_wrap         = (r_presc == w_last_count);

  // An exact compare also sends a zero or multi-bit pos to miss.
  assign w_pos_hit      = (pos == TARGET_MASK);

  // A lap is counted when a step pulse is on the wire while the ring sits on
  // its top bit, i.e. the step is moving it from the top bit back to bit 0.
  assign w_lap_step     = r_ring_en && pos[RING_LEN-1] && (r_lap_cnt != 8'hFF);

  // Game FSM with all outputs registered. Outputs that change on a state
  // change are written on the transition edge, so they line up exactly with
  // the state they belong to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_presc      <= '0;
      r_period     <= BASE_PERIOD;
      r_ring_en    <= 1'b0;
      r_ring_rst_n <= 1'b1;
      r_busy       <= 1'b0;
      r_hit        <= 1'b0;
      r_miss       <= 1'b0;
      r_cap_pos    <= '0;
      r_lap_cnt    <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_RESULT: begin
          r_ring_en <= 1'b0;
          if (start) begin
            // Clear the result right away, so hit/miss are already low in CLEAR.
            r_state      <= S_CLEAR;
            r_ring_rst_n <= 1'b0;
            r_busy       <= 1'b1;
            r_presc      <= '0;
            r_hit        <= 1'b0;
            r_miss       <= 1'b0;
            r_cap_pos    <= '0;
            r_lap_cnt    <= '0;
          end
        end

        S_CLEAR: begin
          r_state      <= S_RUN;
          r_ring_rst_n <= 1'b1;
          r_ring_en    <= 1'b0;
          r_presc      <= '0;
          r_period     <= w_speed_period;
          r_hit        <= 1'b0;
          r_miss       <= 1'b0;
          r_cap_pos    <= '0;
          r_lap_cnt    <= '0;
        end

        S_RUN: begin
          if (w_lap_step) begin
            r_lap_cnt <= r_lap_cnt + 8'd1;
          end
          if (stop) begin
            // stop beats both start and any step pulse due this cycle.
            r_state   <= S_RESULT;
            r_busy    <= 1'b0;
            r_ring_en <= 1'b0;
            r_cap_pos <= pos;
            r_hit     <= w_pos_hit;
            r_miss    <= !w_pos_hit;
          end else if (w_wrap) begin
            r_presc   <= '0;
            r_period  <= w_speed_period;
            r_ring_en <= 1'b1;
          end else begin
            r_presc   <= r_presc + ONE_COUNT;
            r_ring_en <= 1'b0;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign ring_en    = r_ring_en;
  assign ring_rst_n = r_ring_rst_n;
  assign busy       = r_busy;
  assign hit        = r_hit;
  assign miss       = r_miss;
  assign cap_pos    = r_cap_pos;
  assign lap_cnt    = r_lap_cnt;

endmodule

// File: tb/tb_ring_scan_controller.sv
// ---------------------------------------------------------------------------
// tb_ring_scan_controller
//
// Self-checking bench for ring_scan_controller with DIV_BASE = 16. The DUT's
// pos input is driven either by a behavioural ring counter or by a value the
// bench holds steady. Each test queues the step spacings and the result it
// expects. A monitor pops those entries whenever the DUT shows a step pulse
// or enters RESULT.
// ---------------------------------------------------------------------------
module tb_ring_scan_controller;

  localparam int RING_LEN = 15;

  typedef struct {
    logic                hitV;
    logic                missV;
    logic [RING_LEN-1:0] capV;
    logic [7:0]          lapV;
  } resultT;

  logic                clk;
  logic                rst_n;
  logic                start;
  logic                stop;
  logic [1:0]          speed;
  logic [RING_LEN-1:0] pos;
  logic                ring_en;
  logic                ring_rst_n;
  logic                busy;
  logic                hit;
  logic                miss;
  logic [RING_LEN-1:0] cap_pos;
  logic [7:0]          lap_cnt;

  logic                useModel;
  logic [RING_LEN-1:0] forcedPos;
  logic [RING_LEN-1:0] modelPos = 15'h4000;

  int     checks   = 0;
  int     failures = 0;
  int     intervalQ[$];
  resultT resultQ[$];

  ring_scan_controller #(
    .RING_LEN  (RING_LEN),
    .DIV_BASE  (16),
    .DIV_WIDTH (8),
    .TARGET_IDX(7)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .stop      (stop),
    .speed     (speed),
    .pos       (pos),
    .ring_en   (ring_en),
    .ring_rst_n(ring_rst_n),
    .busy      (busy),
    .hit       (hit),
    .miss      (miss),
    .cap_pos   (cap_pos),
    .lap_cnt   (lap_cnt)
  );

  // 10 ns clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ring counter. A clear parks it on the top bit, so the first
  // step wraps it to bit 0.
  always @(posedge clk) begin
    if (!ring_rst_n) begin
      modelPos <= 15'h4000;
    end else if (ring_en) begin
      modelPos <= {modelPos[RING_LEN-2:0], modelPos[RING_LEN-1]};
    end
  end

  assign pos = useModel ? modelPos : forcedPos;

  // Hard stop in case the run never finishes.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Pulses start and/or stop for one clock. It returns 1 ns after the edge
  // that sampled them.
  task automatic applyStimulus(input logic startV, input logic stopV);
    start = startV;
    stop  = stopV;
    @(posedge clk);
    #1;
    start = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pushIntervals(input int value, input int count);
    for (int i = 0; i < count; i++) intervalQ.push_back(value);
  endtask

  task automatic pushResult(input logic h, input logic m,
                            input logic [RING_LEN-1:0] c, input logic [7:0] l);
    resultT r;
    r.hitV  = h;
    r.missV = m;
    r.capV  = c;
    r.lapV  = l;
    resultQ.push_back(r);
  endtask

  // Monitor. It samples on falling edges. The cycle after a ring clear is the
  // reference point for the first step. Each step pulse is compared with the
  // next queued spacing. Each rising edge of hit|miss is compared with the
  // next queued result.
  initial begin
    int     cycle;
    int     lastRef;
    logic   prevResult;
    int     expInterval;
    resultT expRes;
    cycle      = 0;
    lastRef    = 0;
    prevResult = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prevResult = 1'b0;
      end else begin
        cycle++;
        if (ring_en) begin
          checks++;
          if (intervalQ.size() == 0) begin
            failures++;
            $display("[TB] FAIL unexpected ring_en: pulse at cycle %0d, expected none", cycle);
          end else begin
            expInterval = intervalQ.pop_front();
            if ((cycle - lastRef) != expInterval) begin
              failures++;
              $display("[TB] FAIL ring_en spacing: got %0d, expected %0d", cycle - lastRef, expInterval);
            end
          end
          lastRef = cycle;
        end
        if (!ring_rst_n) lastRef = cycle + 1;
        if ((hit || miss) && !prevResult) begin
          if (resultQ.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL unexpected result: hit=%0b miss=%0b, expected no result", hit, miss);
          end else begin
            expRes = resultQ.pop_front();
            checkOutput("result hit", 32'(hit), 32'(expRes.hitV));
            checkOutput("result miss", 32'(miss), 32'(expRes.missV));
            checkOutput("result cap_pos", 32'(cap_pos), 32'(expRes.capV));
            checkOutput("result lap_cnt", 32'(lap_cnt), 32'(expRes.lapV));
            checkOutput("result busy", 32'(busy), 32'(0));
          end
        end
        prevResult = hit || miss;
      end
    end
  end

  // Directed test sequence.
  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    stop      = 1'b0;
    speed     = 2'd0;
    useModel  = 1'b0;
    forcedPos = '0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset ring_en", 32'(ring_en), 32'(0));
    checkOutput("reset ring_rst_n", 32'(ring_rst_n), 32'(1));
    checkOutput("reset busy", 32'(busy), 32'(0));
    checkOutput("reset hit", 32'(hit), 32'(0));
    checkOutput("reset miss", 32'(miss), 32'(0));
    checkOutput("reset cap_pos", 32'(cap_pos), 32'(0));
    checkOutput("reset lap_cnt", 32'(lap_cnt), 32'(0));
    rst_n = 1'b1;
    waitCycles(2);

    // Test 1: speed 0 gives a period of 16. pos is held on the target slot.
    // Step pulses come in cycles 18, 34 and 50. Stop is in cycle 55.
    $display("[TB] test 1: speed 0, stop on target");
    forcedPos = 15'h0080;
    pushIntervals(16, 3);
    pushResult(1'b1, 1'b0, 15'h0080, 8'd0);
    applyStimulus(1'b1, 1'b0);
    checkOutput("clear ring_rst_n", 32'(ring_rst_n), 32'(0));
    checkOutput("clear busy", 32'(busy), 32'(1));
    waitCycles(1);
    checkOutput("run ring_rst_n", 32'(ring_rst_n), 32'(1));
    checkOutput("run busy", 32'(busy), 32'(1));
    checkOutput("run first ring_en", 32'(ring_en), 32'(0));
    waitCycles(53);
    applyStimulus(1'b0, 1'b1);
    checkOutput("result state busy", 32'(busy), 32'(0));

    // Test 2: restart from RESULT with speed 1, using the real ring counter.
    // speed becomes 2 in cycle 20 and 3 in cycle 35. Each change takes effect
    // one step later. Stop in cycle 45 lands on a pending pulse, which must
    // be suppressed. Nine steps leave the ring on bit 8.
    $display("[TB] test 2: speed sweep with ring model");
    useModel = 1'b1;
    speed    = 2'd1;
    intervalQ.push_back(8);
    intervalQ.push_back(8);
    intervalQ.push_back(8);
    intervalQ.push_back(4);
    intervalQ.push_back(4);
    intervalQ.push_back(4);
    intervalQ.push_back(2);
    intervalQ.push_back(2);
    intervalQ.push_back(2);
    pushResult(1'b0, 1'b1, 15'h0100, 8'd1);
    applyStimulus(1'b1, 1'b0);
    checkOutput("restart hit cleared", 32'(hit), 32'(0));
    checkOutput("restart cap cleared", 32'(cap_pos), 32'(0));
    checkOutput("restart lap cleared", 32'(lap_cnt), 32'(0));
    waitCycles(19);
    speed = 2'd2;
    waitCycles(15);
    speed = 2'd3;
    waitCycles(10);
    applyStimulus(1'b0, 1'b1);
    waitCycles(2);
    checkOutput("pos held after stop", 32'(pos), 32'(15'h0100));
    checkOutput("no ring_en in result", 32'(ring_en), 32'(0));

    // Test 3: 31 steps at period 2 starting from a clear. The ring wraps on
    // steps 1, 16 and 31 and ends on bit 0.
    $display("[TB] test 3: lap counting");
    pushIntervals(2, 31);
    pushResult(1'b0, 1'b1, 15'h0001, 8'd3);
    applyStimulus(1'b1, 1'b0);
    waitCycles(64);
    applyStimulus(1'b0, 1'b1);

    // Test 4: pos is not one-hot, and start and stop arrive together in RUN.
    $display("[TB] test 4: start+stop together, non-one-hot pos");
    useModel  = 1'b0;
    forcedPos = 15'h0081;
    speed     = 2'd0;
    pushResult(1'b0, 1'b1, 15'h0081, 8'd0);
    applyStimulus(1'b1, 1'b0);
    waitCycles(4);
    applyStimulus(1'b1, 1'b1);
    waitCycles(2);
    checkOutput("start+stop busy", 32'(busy), 32'(0));
    checkOutput("start+stop ring_rst_n", 32'(ring_rst_n), 32'(1));

    // Test 5: pos is held on the top bit for 300 steps, so lap_cnt saturates.
    $display("[TB] test 5: lap saturation");
    forcedPos = 15'h4000;
    speed     = 2'd3;
    pushIntervals(2, 300);
    pushResult(1'b0, 1'b1, 15'h4000, 8'd255);
    applyStimulus(1'b1, 1'b0);
    waitCycles(602);
    applyStimulus(1'b0, 1'b1);

    // Test 6: asynchronous reset between edges while a step pulse is high.
    // The monitor sees only the pulse in cycle 4.
    $display("[TB] test 6: async reset mid-run");
    pushIntervals(2, 1);
    applyStimulus(1'b1, 1'b0);
    waitCycles(5);
    checkOutput("pre-reset ring_en", 32'(ring_en), 32'(1));
    checkOutput("pre-reset lap_cnt", 32'(lap_cnt), 32'(1));
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async reset ring_en", 32'(ring_en), 32'(0));
    checkOutput("async reset busy", 32'(busy), 32'(0));
    checkOutput("async reset lap_cnt", 32'(lap_cnt), 32'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    waitCycles(3);
    checkOutput("idle after reset busy", 32'(busy), 32'(0));
    checkOutput("idle after reset ring_en", 32'(ring_en), 32'(0));
    applyStimulus(1'b0, 1'b1);
    waitCycles(2);
    checkOutput("stop in idle busy", 32'(busy), 32'(0));
    checkOutput("stop in idle miss", 32'(miss), 32'(0));

    // Everything the tests queued must have been used up.
    checkOutput("pending intervals", 32'(intervalQ.size()), 32'(0));
    checkOutput("pending results", 32'(resultQ.size()), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ring_scan_controller.md
Name: ring_scan_controller

Overview:
- Sequencer for the 15-bit one-hot ring counter used in the midterm light-scan game.
- Generates the counter's step-enable pulses at one of four programmable rates and drives the counter's reset.
- Runs a start/run/stop/result FSM, samples the ring position on stop, and reports hit/miss against a target slot plus a lap count.

Parameters:
- RING_LEN, 15: ring width; width of pos and cap_pos.
- DIV_BASE, 1000000: clocks per step at speed 0. Must be ≥ 8.
- DIV_WIDTH, 20: prescaler width. Must satisfy 2^DIV_WIDTH ≥ DIV_BASE.
- TARGET_IDX, 7: bit index of the winning slot, 0..RING_LEN-1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  start/restart pulse, synchronous, one cycle.
- stop  in  1  stop pulse, synchronous, one cycle.
- speed  in  2  step rate select; period = DIV_BASE >> speed.
- pos  in  RING_LEN  one-hot position fed back from the ring counter.
- ring_en  out  1  step enable to ring counter; one-cycle pulse, registered.
- ring_rst_n  out  1  active-low synchronous clear to ring counter, registered.
- busy  out  1  high in CLEAR or RUN.
- hit  out  1  stop landed on TARGET_IDX; valid in RESULT.
- miss  out  1  stop landed elsewhere, or pos was not one-hot; valid in RESULT.
- cap_pos  out  RING_LEN  pos captured at stop.
- lap_cnt  out  8  completed wraps since start; saturates at 255.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, rst_n). All outputs are registered.
- Reset values:
  - FSM state = IDLE; prescaler = 0.
  - ring_en = 0, ring_rst_n = 1, busy = 0, hit = 0, miss = 0.
  - cap_pos = 0, lap_cnt = 0, period register = DIV_BASE.
- States: IDLE, CLEAR, RUN, RESULT.
- IDLE:
  - ring_en = 0.
  - start → CLEAR. stop is ignored.
- CLEAR (exactly 1 cycle):
  - ring_rst_n = 0 for that cycle.
  - Prescaler, lap_cnt, hit, miss and cap_pos are cleared.
  - Period register loads DIV_BASE >> speed.
  - Unconditionally → RUN.
- RUN, prescaler:
  - Counts 0..period-1.
  - On reaching period-1 it wraps to 0, and ring_en = 1 on the following cycle.
  - Result: successive ring_en pulses are exactly `period` clocks apart.
  - The first pulse occurs `period` clocks after the first RUN cycle.
- RUN, speed changes: speed is resampled into the period register only at each wrap, so a new speed takes effect from the next step.
- RUN, lap counting: when a ring_en pulse is issued while pos[RING_LEN-1] = 1, lap_cnt increments (saturating). The first step after CLEAR (bit 14 → bit 0) counts as lap 1.
- RUN, stop:
  - Capture cap_pos ← pos.
  - hit ← (pos == one-hot(TARGET_IDX)); miss ← !hit.
  - Any ring_en that would have been generated in that cycle is suppressed.
  - → RESULT.
- RUN, other inputs:
  - start is ignored.
  - start and stop in the same cycle: stop wins.
- RESULT:
  - ring_en = 0.
  - hit, miss, cap_pos and lap_cnt are held.
  - start → CLEAR (restart). stop is ignored.
- Non-one-hot pos at stop (zero or multiple bits set): hit = 0, miss = 1, cap_pos holds the raw value.
- hit and miss are mutually exclusive and both 0 outside RESULT.
- busy = 1 exactly in CLEAR and RUN.
- Reset mid-RUN: all registers return to reset values immediately, with no clock edge required; ring_en drops at once.
- Widths: period = DIV_BASE >> speed, zero-extended to DIV_WIDTH. With DIV_BASE ≥ 8 the minimum period is 1, so no zero period is possible.

Test Plan:
- Reset then start (DIV_BASE=16, speed=0): CLEAR 1 cycle with ring_rst_n=0; first ring_en 16 clocks after RUN entry, then every 16 clocks; busy=1.
- Speed sweep (DIV_BASE=16): speed=1,2,3 → ring_en spacing 8, 4, 2 clocks. Changing speed mid-period keeps the current spacing for one step, then switches.
- Stop with pos=1<<7 (TARGET_IDX=7) → RESULT, hit=1, miss=0, cap_pos=15'h0080. Stop with pos=1<<3 → hit=0, miss=1, cap_pos=15'h0008.
- Lap counting: run 31 steps from CLEAR with a real ring counter attached → lap_cnt=3 (wraps at steps 1, 16, 31). Force 300 wraps → lap_cnt=255.
- Edge cases:
  - stop on the same cycle as a pending ring_en → no pulse, pos unchanged.
  - start and stop together in RUN → RESULT.
  - start in RESULT → CLEAR, counters cleared.
  - pos=15'h0081 at stop → miss=1.
- Assert rst_n low mid-RUN between clock edges → ring_en, busy and lap_cnt read 0 before the next edge. After release the FSM sits in IDLE.
